// File: rtl/aes_inv_round_ctrl_pkg.sv
// Shared types and constants for the AES-128 inverse-cipher round sequencer.
package aes_inv_round_ctrl_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_COLS  = 4;
    localparam int KEY_IDX_W = 4;
    localparam int COL_W     = $clog2(AES_COLS);

    typedef enum logic [2:0] {IDLE, ARK0, ISR, ISB, ARK, IMC, DONE} inv_ctrl_state_t;

    typedef logic [KEY_IDX_W-1:0] key_idx_t;
    typedef logic [COL_W-1:0]     col_t;

    function automatic logic is_last_col(col_t c);
        return c == COL_W'(AES_COLS - 1);
    endfunction

endpackage

// File: rtl/aes_inv_round_ctrl_if.sv
// Handshake and datapath-control bundle between the inverse-round sequencer and its datapath.
interface aes_inv_round_ctrl_if;
    import aes_inv_round_ctrl_pkg::*;

    logic     in_valid;
    logic     in_ready;
    logic     abort;
    logic     state_ld;
    logic     ark_en;
    logic     isr_en;
    logic     isb_en;
    col_t     isb_col;
    logic     imc_en;
    key_idx_t key_idx;
    logic     out_valid;
    logic     out_ready;
    logic     busy;

    modport master (
        input  in_valid, abort, out_ready,
        output in_ready, state_ld, ark_en, isr_en, isb_en, isb_col, imc_en,
               key_idx, out_valid, busy
    );

    modport slave (
        output in_valid, abort, out_ready,
        input  in_ready, state_ld, ark_en, isr_en, isb_en, isb_col, imc_en,
               key_idx, out_valid, busy
    );

endinterface

// File: rtl/aes_inv_round_ctrl.sv
// AES-128 InvCipher sequencer: emits per-cycle step enables, InvSubBytes column and round-key index.
//
// state | meaning
// IDLE  | waiting for a ciphertext block, in_ready=1
// ARK0  | initial AddRoundKey with key NR
// ISR   | InvShiftRows
// ISB   | InvSubBytes, one column per cycle
// ARK   | AddRoundKey with key rnd
// IMC   | InvMixColumns, rnd decrements
// DONE  | plaintext valid, waiting for out_ready
module aes_inv_round_ctrl
    import aes_inv_round_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    aes_inv_round_ctrl_if.master  ctl
);

    inv_ctrl_state_t state, state_nxt;
    logic [3:0]      rnd;
    col_t            col;
    logic            ark_q, isr_q, isb_q, imc_q, ov_q;
    key_idx_t        key_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        ctl.state_ld = 1'b0;
        case (state)
            IDLE: begin
                if (ctl.in_valid && !ctl.abort) begin
                    ctl.state_ld = 1'b1;
                    state_nxt    = ARK0;
                end
            end
            ARK0:    state_nxt = ISR;
            ISR:     state_nxt = ISB;
            ISB:     if (is_last_col(col)) state_nxt = ARK;
            ARK:     state_nxt = (rnd == 4'd0) ? DONE : IMC;
            IMC:     state_nxt = ISR;
            DONE:    if (ctl.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (ctl.abort) state_nxt = IDLE;
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ark_q <= 1'b0;
            isr_q <= 1'b0;
            isb_q <= 1'b0;
            imc_q <= 1'b0;
            ov_q  <= 1'b0;
            key_q <= '0;
            col   <= '0;
            rnd   <= '0;
        end else begin
            ark_q <= (state_nxt == ARK0) || (state_nxt == ARK);
            isr_q <= (state_nxt == ISR);
            isb_q <= (state_nxt == ISB);
            imc_q <= (state_nxt == IMC);
            ov_q  <= (state_nxt == DONE);
            if (ctl.abort) begin
                key_q <= '0;
                col   <= '0;
                rnd   <= '0;
            end else begin
                col <= (state == ISB && state_nxt == ISB) ? col + col_t'(1) : '0;
                if (ctl.state_ld)     rnd <= 4'(AES_NR - 1);
                else if (state == IMC) rnd <= rnd - 4'd1;
                if (state_nxt == ARK0)     key_q <= KEY_IDX_W'(AES_NR);
                else if (state_nxt == ARK) key_q <= KEY_IDX_W'(rnd);
            end
        end
    end

    assign ctl.in_ready  = (state == IDLE);
    assign ctl.busy      = (state != IDLE);
    assign ctl.ark_en    = ark_q;
    assign ctl.isr_en    = isr_q;
    assign ctl.isb_en    = isb_q;
    assign ctl.imc_en    = imc_q;
    assign ctl.isb_col   = col;
    assign ctl.key_idx   = key_q;
    assign ctl.out_valid = ov_q;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Directed bench for the AES-128 inverse-round sequencer: trace table, idle vectors, abort/reset cases.
module tb_aes_inv_round_ctrl;
    import aes_inv_round_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_inv_round_ctrl_if bus();

    aes_inv_round_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (bus)
    );

    typedef struct {
        logic       ark, isr, isb, imc;
        logic [1:0] col;
        logic [3:0] key;
        logic       ov, busy, ready;
    } exp_t;

    typedef struct {
        logic iv, ab;
        logic exp_ld, exp_ready, exp_busy;
    } idle_vec_t;

    exp_t      tr [0:79];
    int        n_tr;
    idle_vec_t iv_tab [0:3];

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_ark, cnt_isb, cnt_imc, first_ov;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic a, i, s, m, input logic [1:0] c, input logic [3:0] k, input logic ov);
        tr[n_tr] = '{ark: a, isr: i, isb: s, imc: m, col: c, key: k, ov: ov, busy: 1'b1, ready: 1'b0};
        n_tr++;
    endtask

    function automatic logic [12:0] pack_exp(exp_t e);
        return {e.ark, e.isr, e.isb, e.imc, (e.isb ? e.col : 2'd0), e.key, e.ov, e.busy, e.ready};
    endfunction

    function automatic logic [12:0] pack_act(logic mask_col);
        return {bus.ark_en, bus.isr_en, bus.isb_en, bus.imc_en, (mask_col ? 2'd0 : bus.isb_col),
                bus.key_idx, bus.out_valid, bus.busy, bus.in_ready};
    endfunction

    task automatic check_idle(input string name);
        exp_t e;
        e = '{ark: 0, isr: 0, isb: 0, imc: 0, col: 0, key: 0, ov: 0, busy: 0, ready: 1};
        chk(name, 32'(pack_act(1'b0)), 32'(pack_exp(e)));
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the first sequenced cycle.
    task automatic start_block();
        bus.in_valid = 1'b1;
        bus.abort    = 1'b0;
        #1;
        chk("state_ld_handshake", 32'(bus.state_ld), 32'd1);
        step();
        bus.in_valid = 1'b0;
        cnt_ark = 0; cnt_isb = 0; cnt_imc = 0; first_ov = 0;
    endtask

    task automatic run_trace(input int last);
        for (int n = 1; n <= last; n++) begin
            if (n > 1) step();
            chk($sformatf("trace_c%0d", n), 32'(pack_act(!tr[n-1].isb)), 32'(pack_exp(tr[n-1])));
            if (bus.ark_en) cnt_ark++;
            if (bus.isb_en) cnt_isb++;
            if (bus.imc_en) cnt_imc++;
            if (bus.out_valid && first_ov == 0) first_ov = n;
        end
    endtask

    initial begin
        logic [3:0] cur;

        // Expected trace for one block, cycle 1 = first cycle after the handshake.
        n_tr = 0;
        cur  = 4'd10;
        add(1, 0, 0, 0, 0, cur, 0);
        for (int r = 9; r >= 0; r--) begin
            add(0, 1, 0, 0, 0, cur, 0);
            for (int c = 0; c < 4; c++) add(0, 0, 1, 0, 2'(c), cur, 0);
            cur = 4'(r);
            add(1, 0, 0, 0, 0, cur, 0);
            if (r != 0) add(0, 0, 0, 1, 0, cur, 0);
        end
        add(0, 0, 0, 0, 0, cur, 1);

        iv_tab[0] = '{iv: 0, ab: 0, exp_ld: 0, exp_ready: 1, exp_busy: 0};
        iv_tab[1] = '{iv: 0, ab: 1, exp_ld: 0, exp_ready: 1, exp_busy: 0};
        iv_tab[2] = '{iv: 1, ab: 1, exp_ld: 0, exp_ready: 1, exp_busy: 0};
        iv_tab[3] = '{iv: 1, ab: 0, exp_ld: 1, exp_ready: 1, exp_busy: 0};

        bus.in_valid  = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b1;

        // 1: reset then idle
        #12;
        chk("trace_len", 32'(n_tr), 32'd71);
        check_idle("reset_low");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_idle($sformatf("idle_c%0d", i));
        end

        // 5: idle input vectors (combinational state_ld/in_ready/busy), abort masks the handshake
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = iv_tab[i].iv;
            bus.abort    = iv_tab[i].ab;
            #1;
            chk($sformatf("idle_vec%0d", i), 32'({bus.state_ld, bus.in_ready, bus.busy}),
                32'({iv_tab[i].exp_ld, iv_tab[i].exp_ready, iv_tab[i].exp_busy}));
            if (!iv_tab[i].ab) bus.in_valid = 1'b0;
            step();
            check_idle($sformatf("idle_vec%0d_after", i));
            bus.in_valid = 1'b0;
            bus.abort    = 1'b0;
        end

        // 2: single block with out_ready held high
        bus.out_ready = 1'b1;
        start_block();
        run_trace(71);
        chk("cnt_ark", 32'(cnt_ark), 32'd11);
        chk("cnt_isb", 32'(cnt_isb), 32'd40);
        chk("cnt_imc", 32'(cnt_imc), 32'd9);
        chk("latency", 32'(first_ov), 32'd71);
        step();
        chk("done_to_idle", 32'({bus.out_valid, bus.busy, bus.in_ready}), 32'b001);

        // 3: backpressure in DONE
        step();
        bus.out_ready = 1'b0;
        start_block();
        run_trace(71);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_hold%0d", i), 32'({bus.out_valid, bus.in_ready, bus.busy}), 32'b101);
        end
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("bp_no_ld", 32'(bus.state_ld), 32'd0);
        bus.in_valid = 1'b0;
        step();
        check_idle("bp_release");

        // 4: abort during ISB column 2 of the key-5 round
        step();
        start_block();
        run_trace(33);
        chk("abort_point", 32'({bus.isb_en, bus.isb_col}), 32'b110);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check_idle("abort_idle");
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle($sformatf("abort_quiet%0d", i));
        end
        start_block();
        run_trace(71);
        chk("abort_relatency", 32'(first_ov), 32'd71);
        step();

        // abort coincident with out_ready in DONE discards the transfer
        start_block();
        run_trace(71);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check_idle("abort_in_done");

        // 6: asynchronous reset mid-round, off the clock edge
        step();
        start_block();
        run_trace(20);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        #2;
        rst_n = 1'b1;
        step();
        check_idle("post_reset_idle");
        start_block();
        run_trace(71);
        chk("post_reset_latency", 32'(first_ov), 32'd71);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
